// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the instruction fetch path.
//   fetch_state_t    : fetch FSM states (REQ, WAIT, DRAIN)
//   INSTR_NOP        : instruction word shown to decode when nothing is valid
//   DEFAULT_RESET_PC : default first fetch address
//   FETCH_ENTRY_W    : width of one instruction buffer entry {pc, instr}
// ---------------------------------------------------------------------------
package riscv_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,   // may issue a request
        WAIT  = 2'd1,   // one request outstanding, response will be kept
        DRAIN = 2'd2    // one request outstanding, response will be dropped
    } fetch_state_t;

    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          FETCH_ENTRY_W    = 64;

endpackage

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
// DEPTH-entry synchronous FIFO holding {pc, instr} words between fetch and
// decode. The head entry is readable combinationally so a pushed word is
// visible the cycle after the push. Push while full is accepted only when a
// pop happens in the same cycle. Flush empties the FIFO and wins over push/pop.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : drop all entries
//   push       : write push_data
//   push_data  : entry to write
//   pop        : remove the head entry
//   head_data  : oldest entry (undefined content when empty)
//   full/empty : occupancy flags
// DEPTH must be a power of two, minimum 2.
// ---------------------------------------------------------------------------
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = FETCH_ENTRY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] entry_data [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    // One storage register per entry; only the slot under the write pointer
    // loads. Storage needs no reset since count_reg gates visibility.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] data_reg;
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                    data_reg <= push_data;
                end
            end
            assign entry_data[gi] = data_reg;
        end
    endgenerate

    assign head_data = entry_data[rd_ptr_reg];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: issues one word-aligned request at a time to
// instruction memory, buffers returned words with their PC and hands them to
// decode in order. A redirect from EX flushes everything, drops any response
// still in flight and restarts fetch at the new target.
//   clk, rst          : clock, asynchronous active-high reset
//   imem_req_valid/ready, imem_addr      : request channel
//   imem_rsp_valid, imem_rsp_data        : response channel (in order)
//   redirect_valid, redirect_pc          : taken branch/jump from EX
//   id_ready                             : decode consumes current beat
//   if_valid, if_instruction, if_pc, if_pc_plus4 : beat to decode
//   if_misaligned (FETCH_MISALIGN_CHECK_EN only) : redirect target was not
//                                          word aligned; beat carries a NOP
// Optional feature macro: FETCH_MISALIGN_CHECK_EN. When undefined, redirect
// targets are silently word-aligned.
// ---------------------------------------------------------------------------
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        if_misaligned
`endif
);

    fetch_state_t state_reg;
    fetch_state_t state_next;
    logic [31:0]  pc_reg;
    logic [31:0]  pc_next;
    logic [31:0]  inflight_pc_reg;
    logic [31:0]  redirect_target;
    logic         req_fire;
    logic         rsp_keep;
    logic         buf_pop;
    logic         buf_full;
    logic         buf_empty;
    logic [63:0]  buf_head;
    logic         fetch_halt;
    logic         fault_beat;
    logic [31:0]  fault_pc;
    logic [31:0]  if_pc_int;

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_CHECK_EN
    // A misaligned redirect produces one NOP beat flagged if_misaligned and
    // stops fetching until the next redirect.
    logic        halt_reg;
    logic        fault_reg;
    logic [31:0] fault_pc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_reg     <= 1'b0;
            fault_reg    <= 1'b0;
            fault_pc_reg <= '0;
        end else if (redirect_valid) begin
            halt_reg     <= |redirect_pc[1:0];
            fault_reg    <= |redirect_pc[1:0];
            fault_pc_reg <= redirect_pc;
        end else if (fault_reg && id_ready) begin
            fault_reg <= 1'b0;
        end
    end

    assign fetch_halt    = halt_reg;
    assign fault_beat    = fault_reg;
    assign fault_pc      = fault_pc_reg;
    assign if_misaligned = fault_reg;
`else
    assign fetch_halt = 1'b0;
    assign fault_beat = 1'b0;
    assign fault_pc   = '0;
`endif

    // Gating with rst keeps the request low while reset is held, and lets it
    // rise immediately once reset is released.
    assign imem_req_valid = !rst && (state_reg == REQ) && !buf_full && !fetch_halt;
    assign imem_addr      = pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses are only kept in WAIT, so a response seen in REQ (for example
    // right after reset) or in DRAIN is dropped.
    assign rsp_keep = (state_reg == WAIT) && imem_rsp_valid && !redirect_valid;
    assign buf_pop  = !buf_empty && !fault_beat && id_ready && !redirect_valid;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        if (redirect_valid) begin
            pc_next = redirect_target;
            unique case (state_reg)
                // A request accepted in the redirect cycle is stale already.
                REQ:     state_next = req_fire ? DRAIN : REQ;
                // If the response lands in the redirect cycle nothing is left
                // in flight; otherwise wait it out and drop it.
                WAIT,
                DRAIN:   state_next = imem_rsp_valid ? REQ : DRAIN;
                default: state_next = REQ;
            endcase
        end else begin
            unique case (state_reg)
                REQ: begin
                    if (req_fire) begin
                        state_next = WAIT;
                        pc_next    = pc_reg + 32'd4;
                    end
                end
                WAIT,
                DRAIN: begin
                    if (imem_rsp_valid) begin
                        state_next = REQ;
                    end
                end
                default: state_next = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= REQ;
            pc_reg          <= RESET_PC;
            inflight_pc_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            if (req_fire) begin
                inflight_pc_reg <= pc_reg;
            end
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (FETCH_ENTRY_W)
    ) u_fetch_buffer (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data ({inflight_pc_reg, imem_rsp_data}),
        .pop       (buf_pop),
        .head_data (buf_head),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    // Idle outputs show PC 0 / NOP so decode never sees a stale word.
    always_comb begin
        if_valid       = 1'b0;
        if_pc_int      = '0;
        if_instruction = INSTR_NOP;
        if (fault_beat) begin
            if_valid  = 1'b1;
            if_pc_int = fault_pc;
        end else if (!buf_empty) begin
            if_valid       = 1'b1;
            if_pc_int      = buf_head[63:32];
            if_instruction = buf_head[31:0];
        end
    end

    assign if_pc       = if_pc_int;
    assign if_pc_plus4 = if_pc_int + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit (default build). A small memory model answers
// each accepted request one cycle later with word = addr ^ 32'hA500_0000,
// unless hold is set, in which case the answer is deferred.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    int          total = 0;
    int          bad   = 0;
    logic        pending;
    logic [31:0] pend_addr;
    logic        hold;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA500_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-22s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock: sample the handshake at the falling edge, then update the
    // memory model just after the rising edge.
    task automatic tick();
        logic        acc;
        logic        rsp_now;
        logic [31:0] acc_addr;
        @(negedge clk);
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_addr;
        rsp_now  = imem_rsp_valid;
        @(posedge clk);
        #1;
        if (rsp_now) pending = 1'b0;
        if (acc) begin
            pending   = 1'b1;
            pend_addr = acc_addr;
        end
        imem_rsp_valid = pending && !hold;
        imem_rsp_data  = pending ? mem_word(pend_addr) : 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        pending = 1'b0; pend_addr = '0; hold = 1'b0;

        // Reset is asynchronous: outputs settle before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_if_valid",  {31'b0, if_valid}, 32'd0);
        chk("rst_if_instr",  if_instruction, INSTR_NOP);
        chk("rst_if_pc",     if_pc, 32'h0);
        chk("rst_if_pc4",    if_pc_plus4, 32'h4);
        @(posedge clk); #1;
        tick();
        chk("rst_held_req", {31'b0, imem_req_valid}, 32'd0);

        // Release with a junk response in the first cycle; it must be dropped.
        rst = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        #1;
        chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("first_req_addr",  imem_addr, 32'h0);

        // Straight-line fetch, 1-cycle memory.
        tick();
        chk("s1_wait_req", {31'b0, imem_req_valid}, 32'd0);
        chk("s1_wait_ifv", {31'b0, if_valid}, 32'd0);
        tick();
        chk("s1_pc0",    if_pc, 32'h0);
        chk("s1_pc0_p4", if_pc_plus4, 32'h4);
        chk("s1_ins0",   if_instruction, mem_word(32'h0));
        chk("s1_addr4",  imem_addr, 32'h4);
        tick();
        chk("s1_gap_ifv", {31'b0, if_valid}, 32'd0);
        tick();
        chk("s1_pc4",    if_pc, 32'h4);
        chk("s1_pc4_p4", if_pc_plus4, 32'h8);
        chk("s1_ins4",   if_instruction, mem_word(32'h4));
        tick();
        tick();
        chk("s1_pc8",    if_pc, 32'h8);
        chk("s1_pc8_p4", if_pc_plus4, 32'hC);

        // Decode stalls 5 cycles: buffer fills, requests stop.
        id_ready = 1'b0;
        tick();
        tick();
        chk("s2_full_req", {31'b0, imem_req_valid}, 32'd0);
        chk("s2_hold_pc",  if_pc, 32'h8);
        tick(); tick(); tick();
        chk("s2_still_req", {31'b0, imem_req_valid}, 32'd0);
        chk("s2_still_pc",  if_pc, 32'h8);
        chk("s2_still_ins", if_instruction, mem_word(32'h8));
        id_ready = 1'b1;
        tick();
        chk("s2_pop2_ifv",  {31'b0, if_valid}, 32'd1);
        chk("s2_pop2_pc",   if_pc, 32'hC);
        chk("s2_resume_rq", {31'b0, imem_req_valid}, 32'd1);
        chk("s2_resume_ad", imem_addr, 32'h10);
        tick();
        chk("s2_empty_ifv", {31'b0, if_valid}, 32'd0);
        tick();
        chk("s2_pc10",  if_pc, 32'h10);
        chk("s2_ins10", if_instruction, mem_word(32'h10));

        // Redirect while WAIT with a late response: it must be drained.
        hold = 1'b1;
        tick();
        chk("s3_wait_ifv", {31'b0, if_valid}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("s3_drain_req", {31'b0, imem_req_valid}, 32'd0);
        chk("s3_drain_ifv", {31'b0, if_valid}, 32'd0);
        hold = 1'b0;
        tick();
        chk("s3_rsp_req", {31'b0, imem_req_valid}, 32'd0);
        chk("s3_rsp_ifv", {31'b0, if_valid}, 32'd0);
        tick();
        chk("s3_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("s3_req_addr",  imem_addr, 32'h100);
        chk("s3_no_stale",  {31'b0, if_valid}, 32'd0);
        chk("s3_nop",       if_instruction, INSTR_NOP);
        tick();
        chk("s3_wait2_ifv", {31'b0, if_valid}, 32'd0);
        tick();
        chk("s3_pc100",  if_pc, 32'h100);
        chk("s3_ins100", if_instruction, mem_word(32'h100));

        // Redirect, response and pop all in one cycle.
        tick();
        tick();
        chk("s4_pc104", if_pc, 32'h104);
        id_ready = 1'b0;
        tick();
        chk("s4_held104", if_pc, 32'h104);
        chk("s4_rsp_up",  {31'b0, imem_rsp_valid}, 32'd1);
        id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        chk("s4_ifv",   {31'b0, if_valid}, 32'd0);
        chk("s4_nop",   if_instruction, INSTR_NOP);
        chk("s4_req",   {31'b0, imem_req_valid}, 32'd1);
        chk("s4_addr",  imem_addr, 32'h200);
        tick();
        tick();
        chk("s4_pc200", if_pc, 32'h200);

        // Unaligned redirect target is aligned down.
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        chk("s5_req",  {31'b0, imem_req_valid}, 32'd1);
        chk("s5_addr", imem_addr, 32'h100);
        chk("s5_ifv",  {31'b0, if_valid}, 32'd0);
        tick();
        tick();
        chk("s5_pc100", if_pc, 32'h100);

        // PC wraps past the top of the address space.
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        tick();
        tick();
        chk("wrap_pc",   if_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4",  if_pc_plus4, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Reset asserted mid-cycle while a request is outstanding.
        tick();
        chk("r2_in_wait", {31'b0, imem_req_valid}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("r2_ifv",   {31'b0, if_valid}, 32'd0);
        chk("r2_req",   {31'b0, imem_req_valid}, 32'd0);
        chk("r2_pc",    if_pc, 32'h0);
        chk("r2_pc4",   if_pc_plus4, 32'h4);
        chk("r2_instr", if_instruction, INSTR_NOP);
        @(posedge clk); #1;
        tick();
        rst = 1'b0; pending = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        #1;
        chk("r2_first_req",  {31'b0, imem_req_valid}, 32'd1);
        chk("r2_first_addr", imem_addr, 32'h0);
        tick();
        tick();
        chk("r2_pc0",  if_pc, 32'h0);
        chk("r2_ins0", if_instruction, mem_word(32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
